// File: rtl/hpe_gru_seq_if.sv
// Job/result handshake bundle for hpe_gru_seq: accumulator job in, new hidden state out.
interface hpe_gru_seq_if #(
   parameter int NUM_PE = 4,
   parameter int ACT_BW = 16,
   parameter int ACC_BW = 32,
   parameter int CNT_BW = 16
);
   logic                          din_valid;
   logic                          din_ready;
   logic [NUM_PE-1:0][ACC_BW-1:0] din_acc_r;
   logic [NUM_PE-1:0][ACC_BW-1:0] din_acc_u;
   logic [NUM_PE-1:0][ACC_BW-1:0] din_acc_cx;
   logic [NUM_PE-1:0][ACC_BW-1:0] din_acc_ch;
   logic [NUM_PE-1:0][ACT_BW-1:0] din_hpt;
   logic                          dout_valid;
   logic                          dout_ready;
   logic [NUM_PE-1:0][ACT_BW-1:0] dout_ht;
   logic [CNT_BW-1:0]             done_cnt;

   modport master (
      output din_valid, din_acc_r, din_acc_u, din_acc_cx, din_acc_ch, din_hpt, dout_ready,
      input  din_ready, dout_valid, dout_ht, done_cnt
   );

   modport slave (
      input  din_valid, din_acc_r, din_acc_u, din_acc_cx, din_acc_ch, din_hpt, dout_ready,
      output din_ready, dout_valid, dout_ht, done_cnt
   );
endinterface

// File: rtl/hpe_gru_seq.sv
// Sequenced GRU hidden-state update per lane: h = c + u*(h_prev - c), one job per 7 cycles.
// `define HPE_SAT_EN for saturating clips plus a sticky sat_flag output; otherwise clips wrap.
module hpe_gru_seq #(
   parameter int  NUM_PE     = 4,
   parameter int  ACT_INT_BW = 8,
   parameter int  ACT_FRA_BW = 8,
   parameter int  W_INT_BW   = 8,
   parameter int  W_FRA_BW   = 8,
   parameter int  CNT_BW     = 16,
   localparam int ACT_BW     = ACT_INT_BW + ACT_FRA_BW,
   localparam int ACC_BW     = ACT_BW + W_INT_BW + W_FRA_BW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   hpe_gru_seq_if.slave bus
`ifdef HPE_SAT_EN
   ,
   output logic         sat_flag
`endif
);

   localparam int PRD_BW = 2 * ACT_BW;
   localparam int WIDE   = ((ACC_BW > PRD_BW) ? ACC_BW : PRD_BW) + 2;

   typedef logic signed [ACT_BW-1:0] act_t;
   typedef logic signed [WIDE-1:0]   wide_t;

   typedef enum logic [2:0] {
      S_IDLE, S_SIG, S_MRC, S_TNH, S_DIF, S_MUD, S_HOUT, S_DONE
   } state_t;

   localparam wide_t ONE  = wide_t'(1) <<< ACT_FRA_BW;
   localparam wide_t HALF = ONE >>> 1;
`ifdef HPE_SAT_EN
   localparam wide_t ACT_MAX = (wide_t'(1) <<< (ACT_BW - 1)) - wide_t'(1);
   localparam wide_t ACT_MIN = -ACT_MAX - wide_t'(1);
`endif

   // Arithmetic shift right by k with round-to-nearest, ties to even.
   function automatic wide_t rnd(input wide_t x, input int k);
      wide_t q;
      wide_t rem;
      wide_t half;
      q    = x >>> k;
      rem  = x - (q <<< k);
      half = wide_t'(1) <<< (k - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + wide_t'(1);
      return q;
   endfunction

   function automatic act_t clip(input wide_t x);
      act_t y;
      y = act_t'(x);
`ifdef HPE_SAT_EN
      if (x > ACT_MAX)      y = act_t'(ACT_MAX);
      else if (x < ACT_MIN) y = act_t'(ACT_MIN);
`endif
      return y;
   endfunction

`ifdef HPE_SAT_EN
   function automatic logic ovf(input wide_t x);
      return (x > ACT_MAX) || (x < ACT_MIN);
   endfunction
`endif

   function automatic wide_t acc_ext(input logic [ACC_BW-1:0] a);
      return wide_t'(signed'(a));
   endfunction

   // Piecewise-linear activations: sigmoid = clamp(x/4 + 0.5, 0, 1), tanh = clamp(x, -1, 1).
   function automatic act_t sigmoid_lut(input act_t a);
      wide_t s;
      s = (wide_t'(a) >>> 2) + HALF;
      if (s < 0)        s = '0;
      else if (s > ONE) s = ONE;
      return act_t'(s);
   endfunction

   function automatic act_t tanh_lut(input act_t a);
      wide_t s;
      s = wide_t'(a);
      if (s < -ONE)     s = -ONE;
      else if (s > ONE) s = ONE;
      return act_t'(s);
   endfunction

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic                          w_din_ready;
   logic                          w_load;
   logic                          w_retire;
   logic                          r_valid;
   logic [CNT_BW-1:0]             r_cnt;
   logic [NUM_PE-1:0][ACT_BW-1:0] r_ht;

   act_t r_r  [NUM_PE];
   act_t r_u  [NUM_PE];
   act_t r_cx [NUM_PE];
   act_t r_ch [NUM_PE];
   act_t r_hp [NUM_PE];
   act_t r_rs [NUM_PE];
   act_t r_us [NUM_PE];
   act_t r_p  [NUM_PE];
   act_t r_c  [NUM_PE];
   act_t r_d  [NUM_PE];
   act_t r_q  [NUM_PE];

   wide_t w_r_raw  [NUM_PE];
   wide_t w_u_raw  [NUM_PE];
   wide_t w_cx_raw [NUM_PE];
   wide_t w_ch_raw [NUM_PE];
   wide_t w_p_raw  [NUM_PE];
   wide_t w_s_raw  [NUM_PE];
   wide_t w_d_raw  [NUM_PE];
   wide_t w_q_raw  [NUM_PE];
   wide_t w_h_raw  [NUM_PE];

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      w_din_ready = 1'b0;
      w_load      = 1'b0;
      w_retire    = 1'b0;
      if (en && !rst) begin
         case (r_state)
            S_IDLE: begin
               w_din_ready = 1'b1;
               if (bus.din_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_SIG;
               end
            end
            S_SIG:  w_state_nxt = S_MRC;
            S_MRC:  w_state_nxt = S_TNH;
            S_TNH:  w_state_nxt = S_DIF;
            S_DIF:  w_state_nxt = S_MUD;
            S_MUD:  w_state_nxt = S_HOUT;
            S_HOUT: w_state_nxt = S_DONE;
            S_DONE: begin
               w_din_ready = bus.dout_ready;
               if (bus.dout_ready) begin
                  w_retire    = 1'b1;
                  w_load      = bus.din_valid;
                  w_state_nxt = bus.din_valid ? S_SIG : S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Full-precision stage results; clipping happens when they are registered.
   always_comb begin
      for (int i = 0; i < NUM_PE; i++) begin
         w_r_raw[i]  = rnd(acc_ext(bus.din_acc_r[i]), W_FRA_BW);
         w_u_raw[i]  = rnd(acc_ext(bus.din_acc_u[i]), W_FRA_BW);
         w_cx_raw[i] = rnd(acc_ext(bus.din_acc_cx[i]), W_FRA_BW);
         w_ch_raw[i] = rnd(acc_ext(bus.din_acc_ch[i]), W_FRA_BW);
         w_p_raw[i]  = rnd(wide_t'(r_rs[i]) * wide_t'(r_ch[i]), ACT_FRA_BW);
         w_s_raw[i]  = wide_t'(r_cx[i]) + wide_t'(r_p[i]);
         w_d_raw[i]  = wide_t'(r_hp[i]) - wide_t'(r_c[i]);
         w_q_raw[i]  = rnd(wide_t'(r_us[i]) * wide_t'(r_d[i]), ACT_FRA_BW);
         w_h_raw[i]  = wide_t'(r_c[i]) + wide_t'(r_q[i]);
      end
   end

   // NOTE: non-blocking assignments so each stage reads the previous cycle's values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_cnt   <= '0;
         r_ht    <= '0;
         // NOTE: the per-lane stage registers are plain flops, so they are cleared explicitly.
         for (int i = 0; i < NUM_PE; i++) begin
            r_r[i]  <= '0;
            r_u[i]  <= '0;
            r_cx[i] <= '0;
            r_ch[i] <= '0;
            r_hp[i] <= '0;
            r_rs[i] <= '0;
            r_us[i] <= '0;
            r_p[i]  <= '0;
            r_c[i]  <= '0;
            r_d[i]  <= '0;
            r_q[i]  <= '0;
         end
      end else if (en) begin
         r_state <= w_state_nxt;
         if (r_state == S_HOUT) r_valid <= 1'b1;
         else if (w_retire)     r_valid <= 1'b0;
         if (w_retire) r_cnt <= r_cnt + CNT_BW'(1);
         for (int i = 0; i < NUM_PE; i++) begin
            if (w_load) begin
               r_r[i]  <= clip(w_r_raw[i]);
               r_u[i]  <= clip(w_u_raw[i]);
               r_cx[i] <= clip(w_cx_raw[i]);
               r_ch[i] <= clip(w_ch_raw[i]);
               r_hp[i] <= act_t'(bus.din_hpt[i]);
            end
            case (r_state)
               S_SIG: begin
                  r_rs[i] <= sigmoid_lut(r_r[i]);
                  r_us[i] <= sigmoid_lut(r_u[i]);
               end
               S_MRC:   r_p[i]  <= clip(w_p_raw[i]);
               S_TNH:   r_c[i]  <= tanh_lut(clip(w_s_raw[i]));
               S_DIF:   r_d[i]  <= clip(w_d_raw[i]);
               S_MUD:   r_q[i]  <= clip(w_q_raw[i]);
               S_HOUT:  r_ht[i] <= clip(w_h_raw[i]);
               default: ;
            endcase
         end
      end
   end

`ifdef HPE_SAT_EN
   logic w_sat_hit;
   logic r_sat;

   always_comb begin
      w_sat_hit = 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (w_load)
            w_sat_hit |= ovf(w_r_raw[i]) | ovf(w_u_raw[i]) | ovf(w_cx_raw[i]) | ovf(w_ch_raw[i]);
         case (r_state)
            S_MRC:   w_sat_hit |= ovf(w_p_raw[i]);
            S_TNH:   w_sat_hit |= ovf(w_s_raw[i]);
            S_DIF:   w_sat_hit |= ovf(w_d_raw[i]);
            S_MUD:   w_sat_hit |= ovf(w_q_raw[i]);
            S_HOUT:  w_sat_hit |= ovf(w_h_raw[i]);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                   r_sat <= 1'b0;
      else if (en && w_sat_hit)  r_sat <= 1'b1;
   end

   assign sat_flag = r_sat;
`endif

   assign bus.din_ready  = w_din_ready;
   assign bus.dout_valid = r_valid;
   assign bus.dout_ht    = r_ht;
   assign bus.done_cnt   = r_cnt;

endmodule

// File: tb/tb_hpe_gru_seq.sv
// Directed bench for hpe_gru_seq (Q8.8 activations, 1.0 = 256); expected values hand-computed.
module tb_hpe_gru_seq;
   localparam int NUM_PE = 4;
   localparam int ACT_BW = 16;
   localparam int ACC_BW = 32;
   localparam int CNT_BW = 16;

   typedef logic [NUM_PE-1:0][ACC_BW-1:0] accv_t;
   typedef logic [NUM_PE-1:0][ACT_BW-1:0] actv_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   int                checks   = 0;
   int                failures = 0;
   logic [CNT_BW-1:0] exp_cnt;
`ifdef HPE_SAT_EN
   logic              sat_flag;
`endif

   hpe_gru_seq_if #(.NUM_PE(NUM_PE), .ACT_BW(ACT_BW), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) bus ();

   hpe_gru_seq #(
      .NUM_PE(NUM_PE), .ACT_INT_BW(8), .ACT_FRA_BW(8), .W_INT_BW(8), .W_FRA_BW(8), .CNT_BW(CNT_BW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .bus(bus)
`ifdef HPE_SAT_EN
      ,
      .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   // Vectors (lane3 .. lane0)
   localparam accv_t ZERO_ACC = '0;
   localparam actv_t V1_HP    = {16'd256, 16'd256, 16'd256, 16'd256};
   localparam actv_t V1_EXP   = {16'd128, 16'd128, 16'd128, 16'd128};
   localparam actv_t V2_HP    = {16'd3, 16'd1, 16'd3, 16'd1};
   localparam actv_t V2_EXP   = {16'd2, 16'd0, 16'd2, 16'd0};
   localparam actv_t V3_HP    = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
   localparam actv_t V3A_EXP  = {16'd16384, 16'd16384, 16'd16384, 16'd16384};
   localparam accv_t V3_CX    = {32'd0, 32'h8000_0000, 32'hFFFF_0000, 32'd0};
`ifdef HPE_SAT_EN
   localparam actv_t V3B_EXP  = {16'd16384, 16'd16128, 16'd16128, 16'd16384};
`else
   localparam actv_t V3B_EXP  = {16'd16384, 16'd16384, 16'hBF80, 16'd16384};
`endif
   localparam accv_t V4_R     = {32'h0008_0000, 32'd0, 32'd0, 32'h0001_0000};
   localparam accv_t V4_U     = {32'd0, 32'd0, 32'h0001_0000, 32'hFFFE_0000};
   localparam accv_t V4_CX    = {32'h0000_0480, 32'h0000_0380, 32'd0, 32'hFFFF_8000};
   localparam accv_t V4_CH    = {32'h0000_0A00, 32'd0, 32'h0000_6400, 32'h0002_0000};
   localparam actv_t V4_HP    = {16'd0, 16'd0, 16'hFF9C, 16'd0};
   localparam actv_t V4_EXP   = {16'd7, 16'd2, 16'hFFC2, 16'd256};

   task automatic set_job(input accv_t r, input accv_t u, input accv_t cx, input accv_t ch,
                          input actv_t hp);
      bus.din_acc_r  = r;
      bus.din_acc_u  = u;
      bus.din_acc_cx = cx;
      bus.din_acc_ch = ch;
      bus.din_hpt    = hp;
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic start_job(output logic ok);
      bus.din_valid = 1'b1;
      #1 ok = bus.din_ready;
      @(negedge clk);
      bus.din_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int lat);
      lat = 0;
      while (bus.dout_valid !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic retire();
      bus.dout_ready = 1'b1;
      @(negedge clk);
      bus.dout_ready = 1'b0;
      exp_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.din_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_din_ready_in_rst got=%b exp=0", bus.din_ready);
      end
      rst = 1'b0;
      exp_cnt = '0;
      #1;
      checks++;
      if ({bus.dout_valid, bus.din_ready, bus.done_cnt} !== {1'b0, 1'b1, 16'd0}) begin
         failures++;
         $display("FAIL reset_ctrl got valid=%b ready=%b cnt=%0d exp valid=0 ready=1 cnt=0",
                  bus.dout_valid, bus.din_ready, bus.done_cnt);
      end
      checks++;
      if (bus.dout_ht !== '0) begin
         failures++;
         $display("FAIL reset_ht got=%h exp=0", bus.dout_ht);
      end
`ifdef HPE_SAT_EN
      checks++;
      if (sat_flag !== 1'b0) begin
         failures++;
         $display("FAIL reset_sat_flag got=%b exp=0", sat_flag);
      end
`endif
   endtask

   task automatic test_basic();
      logic ok;
      int   lat;
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V1_HP);
      start_job(ok);
      checks++;
      if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", ok); end
      wait_valid(30, lat);
      checks++;
      if (lat != 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", lat); end
      for (int i = 0; i < NUM_PE; i++) begin
         checks++;
         if (bus.dout_ht[i] !== V1_EXP[i]) begin
            failures++;
            $display("FAIL basic_ht lane%0d got=%0d exp=%0d", i, $signed(bus.dout_ht[i]),
                     $signed(V1_EXP[i]));
         end
      end
      retire();
      checks++;
      if ({bus.dout_valid, bus.done_cnt} !== {1'b0, exp_cnt}) begin
         failures++;
         $display("FAIL basic_retire got valid=%b cnt=%0d exp valid=0 cnt=%0d",
                  bus.dout_valid, bus.done_cnt, exp_cnt);
      end
   endtask

   task automatic test_round();
      logic ok;
      int   lat;
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V2_HP);
      start_job(ok);
      wait_valid(30, lat);
      for (int i = 0; i < NUM_PE; i++) begin
         checks++;
         if (bus.dout_ht[i] !== V2_EXP[i]) begin
            failures++;
            $display("FAIL round_ht lane%0d got=%0d exp=%0d", i, $signed(bus.dout_ht[i]),
                     $signed(V2_EXP[i]));
         end
      end
      retire();
   endtask

   task automatic test_sat();
      logic ok;
      int   lat;
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V3_HP);
      start_job(ok);
      wait_valid(30, lat);
      for (int i = 0; i < NUM_PE; i++) begin
         checks++;
         if (bus.dout_ht[i] !== V3A_EXP[i]) begin
            failures++;
            $display("FAIL sat_max_ht lane%0d got=%0d exp=%0d", i, $signed(bus.dout_ht[i]),
                     $signed(V3A_EXP[i]));
         end
      end
`ifdef HPE_SAT_EN
      checks++;
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_flag_quiet got=%b exp=0", sat_flag); end
`endif
      retire();
      set_job(ZERO_ACC, ZERO_ACC, V3_CX, ZERO_ACC, V3_HP);
      start_job(ok);
      wait_valid(30, lat);
      for (int i = 0; i < NUM_PE; i++) begin
         checks++;
         if (bus.dout_ht[i] !== V3B_EXP[i]) begin
            failures++;
            $display("FAIL sat_clip_ht lane%0d got=%0d exp=%0d", i, $signed(bus.dout_ht[i]),
                     $signed(V3B_EXP[i]));
         end
      end
`ifdef HPE_SAT_EN
      checks++;
      if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag_set got=%b exp=1", sat_flag); end
`endif
      retire();
   endtask

   task automatic test_func();
      logic ok;
      int   lat;
      set_job(V4_R, V4_U, V4_CX, V4_CH, V4_HP);
      start_job(ok);
      wait_valid(30, lat);
      checks++;
      if (lat != 6) begin failures++; $display("FAIL func_latency got=%0d exp=6", lat); end
      for (int i = 0; i < NUM_PE; i++) begin
         checks++;
         if (bus.dout_ht[i] !== V4_EXP[i]) begin
            failures++;
            $display("FAIL func_ht lane%0d got=%0d exp=%0d", i, $signed(bus.dout_ht[i]),
                     $signed(V4_EXP[i]));
         end
      end
      retire();
   endtask

   task automatic test_back_to_back();
      logic ok;
      int   lat;
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V1_HP);
      start_job(ok);
      wait_valid(30, lat);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if ({bus.dout_valid, bus.din_ready, bus.dout_ht} !== {1'b1, 1'b0, V1_EXP}) begin
            failures++;
            $display("FAIL b2b_hold cyc%0d got valid=%b ready=%b ht=%h exp valid=1 ready=0 ht=%h",
                     k, bus.dout_valid, bus.din_ready, bus.dout_ht, V1_EXP);
         end
      end
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V2_HP);
      bus.din_valid  = 1'b1;
      bus.dout_ready = 1'b1;
      #1;
      checks++;
      if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL b2b_din_ready got=%b exp=1", bus.din_ready); end
      @(negedge clk);
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      exp_cnt++;
      checks++;
      if ({bus.dout_valid, bus.done_cnt} !== {1'b0, exp_cnt}) begin
         failures++;
         $display("FAIL b2b_first_retire got valid=%b cnt=%0d exp valid=0 cnt=%0d",
                  bus.dout_valid, bus.done_cnt, exp_cnt);
      end
      wait_valid(30, lat);
      checks++;
      if (lat != 6) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=6", lat); end
      checks++;
      if (bus.dout_ht !== V2_EXP) begin
         failures++;
         $display("FAIL b2b_second_ht got=%h exp=%h", bus.dout_ht, V2_EXP);
      end
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V1_HP);
      bus.din_valid  = 1'b1;
      bus.dout_ready = 1'b1;
      @(negedge clk);
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      exp_cnt++;
      wait_valid(30, lat);
      checks++;
      if (lat + 1 != 7) begin failures++; $display("FAIL b2b_spacing got=%0d exp=7", lat + 1); end
      checks++;
      if (bus.dout_ht !== V1_EXP) begin
         failures++;
         $display("FAIL b2b_third_ht got=%h exp=%h", bus.dout_ht, V1_EXP);
      end
      retire();
      checks++;
      if (bus.done_cnt !== exp_cnt) begin
         failures++;
         $display("FAIL b2b_cnt got=%0d exp=%0d", bus.done_cnt, exp_cnt);
      end
   endtask

   task automatic test_stall();
      logic ok;
      int   lat;
      int   lat2;
      set_job(V4_R, V4_U, V4_CX, V4_CH, V4_HP);
      start_job(ok);
      @(negedge clk);
      lat = 1;
      en  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         lat++;
         checks++;
         if ({bus.din_ready, bus.dout_valid} !== 2'b00) begin
            failures++;
            $display("FAIL stall_frozen got ready=%b valid=%b exp ready=0 valid=0",
                     bus.din_ready, bus.dout_valid);
         end
      end
      en = 1'b1;
      wait_valid(30, lat2);
      checks++;
      if (lat + lat2 != 9) begin failures++; $display("FAIL stall_latency got=%0d exp=9", lat + lat2); end
      checks++;
      if (bus.dout_ht !== V4_EXP) begin
         failures++;
         $display("FAIL stall_ht got=%h exp=%h", bus.dout_ht, V4_EXP);
      end
      en = 1'b0;
      bus.dout_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({bus.dout_valid, bus.din_ready, bus.done_cnt, bus.dout_ht} !==
             {1'b1, 1'b0, exp_cnt, V4_EXP}) begin
            failures++;
            $display("FAIL stall_done_frozen got valid=%b ready=%b cnt=%0d exp valid=1 ready=0 cnt=%0d",
                     bus.dout_valid, bus.din_ready, bus.done_cnt, exp_cnt);
         end
      end
      en = 1'b1;
      @(negedge clk);
      bus.dout_ready = 1'b0;
      exp_cnt++;
      checks++;
      if ({bus.dout_valid, bus.done_cnt} !== {1'b0, exp_cnt}) begin
         failures++;
         $display("FAIL stall_retire got valid=%b cnt=%0d exp valid=0 cnt=%0d",
                  bus.dout_valid, bus.done_cnt, exp_cnt);
      end
   endtask

   task automatic test_rst_mid();
      logic ok;
      int   lat;
      set_job(V4_R, V4_U, V4_CX, V4_CH, V4_HP);
      start_job(ok);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
      #1;
      checks++;
      if ({bus.dout_valid, bus.din_ready, bus.done_cnt} !== {1'b0, 1'b1, 16'd0}) begin
         failures++;
         $display("FAIL rstmid_ctrl got valid=%b ready=%b cnt=%0d exp valid=0 ready=1 cnt=0",
                  bus.dout_valid, bus.din_ready, bus.done_cnt);
      end
`ifdef HPE_SAT_EN
      checks++;
      if (sat_flag !== 1'b0) begin failures++; $display("FAIL rstmid_sat_flag got=%b exp=0", sat_flag); end
`endif
      @(negedge clk);
      checks++;
      if (bus.dout_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_no_ghost got=%b exp=0", bus.dout_valid);
      end
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, V1_HP);
      start_job(ok);
      wait_valid(30, lat);
      checks++;
      if (lat != 6) begin failures++; $display("FAIL rstmid_latency got=%0d exp=6", lat); end
      checks++;
      if (bus.dout_ht !== V1_EXP) begin
         failures++;
         $display("FAIL rstmid_ht got=%h exp=%h", bus.dout_ht, V1_EXP);
      end
      retire();
      checks++;
      if (bus.done_cnt !== exp_cnt) begin
         failures++;
         $display("FAIL rstmid_cnt got=%0d exp=%0d", bus.done_cnt, exp_cnt);
      end
   endtask

   initial begin
      rst            = 1'b1;
      en             = 1'b1;
      exp_cnt        = '0;
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b0;
      set_job(ZERO_ACC, ZERO_ACC, ZERO_ACC, ZERO_ACC, '0);
      test_reset();
      test_basic();
      test_round();
      test_sat();
      test_func();
      test_back_to_back();
      test_stall();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
